// File: rtl/xor_pair_eval_sched_pkg.sv
// ============================================================================
// Package  : xor_pair_pkg
// Desc     : Operand layout shared by the xor-pair scheduler and its evaluator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package xor_pair_pkg;

    localparam int OPW   = 4;
    localparam int A_BIT = 0;
    localparam int B_BIT = 1;
    localparam int C_BIT = 2;
    localparam int D_BIT = 3;

    typedef logic [OPW-1:0] operand_t;

endpackage : xor_pair_pkg

`default_nettype wire

// File: rtl/xor_pair_eval_sched_eval.sv
// ============================================================================
// Module   : xor_pair_eval
// Desc     : Combinational evaluator f = (a ^ b) & (c ^ d) on one operand.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xor_pair_eval
    import xor_pair_pkg::*;
(
    input  operand_t operand,
    output logic     f
);

    assign f = (operand[A_BIT] ^ operand[B_BIT]) & (operand[C_BIT] ^ operand[D_BIT]);

endmodule : xor_pair_eval

`default_nettype wire

// File: rtl/xor_pair_eval_sched.sv
// ============================================================================
// Module   : xor_pair_eval_sched
// Desc     : Round-robin scheduler sharing one xor-pair evaluator, registered result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xor_pair_eval_sched
    import xor_pair_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int CNT_W   = 16,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [OPW*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_result,
    output logic [CNT_W-1:0]       eval_cnt
);

    logic             rsp_valid_q,  rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q,     rsp_id_d;
    logic             rsp_result_q, rsp_result_d;
    logic [ID_W-1:0]  rr_ptr_q,     rr_ptr_d;
    logic [CNT_W-1:0] eval_cnt_q,   eval_cnt_d;

    logic             out_free;
    logic             found;
    logic             grant;
    logic [ID_W-1:0]  winner;
    operand_t         ops [NUM_REQ];
    operand_t         sel_op;
    logic             sel_f;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign ops[gi] = req_data[gi*OPW +: OPW];
        end
    endgenerate

    // A fresh result may land whenever the register is empty or is being drained this cycle.
    assign out_free = ~rsp_valid_q | rsp_ready;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                found  = 1'b1;
                winner = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    assign grant = en & out_free & found;

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign sel_op = ops[winner];

    xor_pair_eval u_eval (
        .operand (sel_op),
        .f       (sel_f)
    );

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rr_ptr_d     = rr_ptr_q;
        eval_cnt_d   = eval_cnt_q;
        if (grant) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = winner;
            rsp_result_d = sel_f;
            rr_ptr_d     = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
            eval_cnt_d   = eval_cnt_q + CNT_W'(1);
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= 1'b0;
            rr_ptr_q     <= '0;
            eval_cnt_q   <= '0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rr_ptr_q     <= rr_ptr_d;
            eval_cnt_q   <= eval_cnt_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign eval_cnt   = eval_cnt_q;

endmodule : xor_pair_eval_sched

`default_nettype wire

// File: tb/tb_xor_pair_eval_sched.sv
// ============================================================================
// Module   : tb_xor_pair_eval_sched
// Desc     : Scoreboard bench for the xor-pair scheduler (default and 4-bit counter builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xor_pair_eval_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [15:0] req_data = '0;

    logic [3:0]  req_ready,  req_ready4;
    logic        rsp_valid,  rsp_valid4;
    logic [1:0]  rsp_id,     rsp_id4;
    logic        rsp_result, rsp_result4;
    logic [15:0] eval_cnt;
    logic [3:0]  eval_cnt4;

    int tests = 0;
    int fails = 0;
    int m_cnt = 0;
    int m_ptr = 0;

    typedef struct packed {
        logic [1:0] id;
        logic       res;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    xor_pair_eval_sched #(.NUM_REQ(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .eval_cnt(eval_cnt)
    );

    xor_pair_eval_sched #(.NUM_REQ(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready4), .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id4), .rsp_result(rsp_result4), .eval_cnt(eval_cnt4)
    );

    function automatic logic ref_f(input logic [3:0] x);
        return (x[0] ^ x[1]) & (x[2] ^ x[3]);
    endfunction

    function automatic int model_winner(input logic [3:0] v, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return 0;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input int w, input logic [3:0] op);
        exp_t e;
        e.id  = 2'(w);
        e.res = ref_f(op);
        sb.push_back(e);
        m_cnt = m_cnt + 1;
        m_ptr = (w + 1) % 4;
    endtask

    // Pops one expected entry for every result handed to the consumer.
    task automatic monitor;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL sb_underflow: got id=%0d res=%0b, expected no result", rsp_id, rsp_result);
                end else begin
                    mon_e = sb.pop_front();
                    if (rsp_id !== mon_e.id || rsp_result !== mon_e.res ||
                        rsp_id4 !== mon_e.id || rsp_result4 !== mon_e.res || rsp_valid4 !== 1'b1) begin
                        fails++;
                        $display("FAIL sb_rsp: got id=%0d res=%0b (cnt4 build id=%0d res=%0b), expected id=%0d res=%0b",
                                 rsp_id, rsp_result, rsp_id4, rsp_result4, mon_e.id, mon_e.res);
                    end
                end
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_result !== 1'b0 ||
            eval_cnt !== 16'd0 || eval_cnt4 !== 4'd0 || req_ready !== 4'd0) begin
            fails++;
            $display("FAIL reset_state: got v=%0b id=%0d r=%0b cnt=%0d cnt4=%0d rdy=%b, expected all zero",
                     rsp_valid, rsp_id, rsp_result, eval_cnt, eval_cnt4, req_ready);
        end
        tick;
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        logic [3:0] op;
        tick;
        en = 1'b1; rsp_ready = 1'b1; req_valid = 4'b0001;
        op = 4'b0101; req_data = {12'h000, op};
        @(negedge clk);
        tests++;
        if (req_ready !== 4'b0001) begin
            fails++; $display("FAIL single_grant0: got req_ready=%b, expected 0001", req_ready);
        end
        accept(0, op);
        tick;
        op = 4'b0011; req_data = {12'h000, op};
        @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 1'b1) begin
            fails++; $display("FAIL single_rsp0: got v=%0b id=%0d r=%0b, expected v=1 id=0 r=1", rsp_valid, rsp_id, rsp_result);
        end
        tests++;
        if (req_ready !== 4'b0001) begin
            fails++; $display("FAIL single_grant1: got req_ready=%b, expected 0001", req_ready);
        end
        accept(0, op);
        tick;
        req_valid = 4'b0000;
        @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b1 || rsp_result !== 1'b0) begin
            fails++; $display("FAIL single_rsp1: got v=%0b r=%0b, expected v=1 r=0", rsp_valid, rsp_result);
        end
        tick;
        @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b0) begin
            fails++; $display("FAIL single_drain: got rsp_valid=%0b, expected 0", rsp_valid);
        end
    endtask

    task automatic test_round_robin;
        int w;
        int start_cnt;
        tick;
        en = 1'b1; rsp_ready = 1'b1; req_valid = 4'hF;
        req_data = 16'($urandom);
        start_cnt = m_cnt;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            w = model_winner(req_valid, m_ptr);
            tests++;
            if (req_ready !== 4'(1 << w)) begin
                fails++; $display("FAIL rr_grant[%0d]: got req_ready=%b, expected %b", c, req_ready, 4'(1 << w));
            end
            if (c > 0) begin
                tests++;
                if (rsp_valid !== 1'b1) begin
                    fails++; $display("FAIL rr_throughput[%0d]: got rsp_valid=%0b, expected 1", c, rsp_valid);
                end
            end
            accept(w, req_data[w*4 +: 4]);
            tick;
            req_data[w*4 +: 4] = 4'($urandom);
        end
        req_valid = 4'b0000;
        @(negedge clk);
        tests++;
        if (eval_cnt !== 16'(start_cnt + 8) || eval_cnt4 !== 4'(start_cnt + 8)) begin
            fails++; $display("FAIL rr_count: got cnt=%0d cnt4=%0d, expected %0d", eval_cnt, eval_cnt4, start_cnt + 8);
        end
    endtask

    task automatic test_backpressure;
        tick;
        req_valid = 4'b0000; rsp_ready = 1'b1;
        tick;
        req_valid = 4'b0010; req_data[7:4] = 4'b0110; rsp_ready = 1'b0;
        @(negedge clk);
        tests++;
        if (req_ready !== 4'b0010) begin
            fails++; $display("FAIL bp_first_grant: got req_ready=%b, expected 0010", req_ready);
        end
        accept(1, 4'b0110);
        tick;
        req_valid = 4'b0100; req_data[11:8] = 4'b1100;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests++;
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd1 ||
                rsp_result !== 1'b1 || eval_cnt !== 16'(m_cnt)) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got rdy=%b v=%0b id=%0d r=%0b cnt=%0d, expected rdy=0000 v=1 id=1 r=1 cnt=%0d",
                         c, req_ready, rsp_valid, rsp_id, rsp_result, eval_cnt, m_cnt);
            end
            tick;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (req_ready !== 4'b0100) begin
            fails++; $display("FAIL bp_release_grant: got req_ready=%b, expected 0100", req_ready);
        end
        accept(2, 4'b1100);
        tick;
        req_valid = 4'b0000;
        @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 1'b0) begin
            fails++; $display("FAIL bp_replace: got v=%0b id=%0d r=%0b, expected v=1 id=2 r=0", rsp_valid, rsp_id, rsp_result);
        end
    endtask

    task automatic test_enable;
        tick;
        en = 1'b0; rsp_ready = 1'b1; req_valid = 4'b0100; req_data[11:8] = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if (req_ready !== 4'b0000 || eval_cnt !== 16'(m_cnt)) begin
                fails++; $display("FAIL en_off[%0d]: got rdy=%b cnt=%0d, expected rdy=0000 cnt=%0d", c, req_ready, eval_cnt, m_cnt);
            end
            tick;
        end
        en = 1'b1;
        @(negedge clk);
        tests++;
        if (req_ready !== 4'b0100) begin
            fails++; $display("FAIL en_on_grant: got req_ready=%b, expected 0100", req_ready);
        end
        accept(2, 4'b1010);
        tick;
        req_valid = 4'b0000;
        @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 1'b1) begin
            fails++; $display("FAIL en_on_rsp: got v=%0b id=%0d r=%0b, expected v=1 id=2 r=1", rsp_valid, rsp_id, rsp_result);
        end
    endtask

    task automatic test_reset_midstream;
        int w;
        tick;
        en = 1'b1; rsp_ready = 1'b1; req_valid = 4'hF; req_data = 16'($urandom);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            w = model_winner(req_valid, m_ptr);
            tests++;
            if (req_ready !== 4'(1 << w)) begin
                fails++; $display("FAIL rst_pre_grant[%0d]: got req_ready=%b, expected %b", c, req_ready, 4'(1 << w));
            end
            accept(w, req_data[w*4 +: 4]);
            tick;
            req_data[w*4 +: 4] = 4'($urandom);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_result !== 1'b0 ||
            eval_cnt !== 16'd0 || eval_cnt4 !== 4'd0) begin
            fails++; $display("FAIL rst_async: got v=%0b id=%0d r=%0b cnt=%0d cnt4=%0d, expected all zero",
                              rsp_valid, rsp_id, rsp_result, eval_cnt, eval_cnt4);
        end
        sb.delete();
        m_cnt = 0;
        m_ptr = 0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        req_valid = 4'b1001; req_data = 16'h5006;
        @(negedge clk);
        tests++;
        if (req_ready !== 4'b0001) begin
            fails++; $display("FAIL rst_ptr_restart: got req_ready=%b, expected 0001", req_ready);
        end
        accept(0, 4'b0110);
        tick;
        req_valid = 4'b1000;
        @(negedge clk);
        tests++;
        if (req_ready !== 4'b1000) begin
            fails++; $display("FAIL rst_second_grant: got req_ready=%b, expected 1000", req_ready);
        end
        accept(3, 4'b0101);
        tick;
        req_valid = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_wrap_exhaustive;
        logic [3:0] op;
        int r;
        tick;
        req_valid = 4'b0000; rsp_ready = 1'b1; en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        sb.delete();
        m_cnt = 0;
        m_ptr = 0;
        for (int v = 0; v < 17; v++) begin
            op = 4'(v);
            r = v % 4;
            req_data = '0;
            req_data[r*4 +: 4] = op;
            req_valid = 4'(1 << r);
            @(negedge clk);
            tests++;
            if (req_ready !== 4'(1 << r)) begin
                fails++; $display("FAIL wrap_grant[%0d]: got req_ready=%b, expected %b", v, req_ready, 4'(1 << r));
            end
            if (v == 16) begin
                tests++;
                if (eval_cnt4 !== 4'd0 || eval_cnt !== 16'd16) begin
                    fails++; $display("FAIL wrap_at16: got cnt4=%0d cnt=%0d, expected cnt4=0 cnt=16", eval_cnt4, eval_cnt);
                end
            end
            accept(r, op);
            tick;
        end
        req_valid = 4'b0000;
        @(negedge clk);
        tests++;
        if (eval_cnt4 !== 4'd1 || eval_cnt !== 16'd17) begin
            fails++; $display("FAIL wrap_at17: got cnt4=%0d cnt=%0d, expected cnt4=1 cnt=17", eval_cnt4, eval_cnt);
        end
        tick;
        @(negedge clk);
        tests++;
        if (sb.size() != 0 || rsp_valid !== 1'b0) begin
            fails++; $display("FAIL sb_leftover: got %0d pending, rsp_valid=%0b, expected 0 pending and idle", sb.size(), rsp_valid);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_enable();
        test_reset_midstream();
        test_wrap_exhaustive();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_xor_pair_eval_sched

`default_nettype wire
